control_sequencer: RTL and testbench

//  Hardwired control unit directly upstream of the Datapath. Replaces the hand-driven T-state

---
 rtl/control_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the Datapath.
// Steps through fetch (T0-T2), decodes IR in T3 and drives the register/ALU
// strobes for reg-reg, unary and mul/div instructions. Every strobe is a
// Moore output decoded from the state register; register selects come from IR,
// which is stable from T3 until the next fetch.
module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int CTRL_W   = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run,
    input  logic                MemRdy,
    input  logic [31:0]         IR,
    output logic                PC_Out,
    output logic                MDR_Out,
    output logic                ZLO_Out,
    output logic                ZHI_Out,
    output logic                PC_In,
    output logic                MDR_In,
    output logic                MAR_In,
    output logic                IR_In,
    output logic                Y_In,
    output logic                ZLO_In,
    output logic                ZHI_In,
    output logic                LO_In,
    output logic                HI_In,
    output logic                IncPC,
    output logic                Read,
    output logic [NUM_REGS-1:0] R_Out,
    output logic [NUM_REGS-1:0] R_In,
    output logic [CTRL_W-1:0]   CONTROL,
    output logic                Done,
    output logic                Fault
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] T0      = 4'd1;
    localparam logic [3:0] T1      = 4'd2;
    localparam logic [3:0] T2      = 4'd3;
    localparam logic [3:0] T3      = 4'd4;
    localparam logic [3:0] T4      = 4'd5;
    localparam logic [3:0] T5      = 4'd6;
    localparam logic [3:0] T6      = 4'd7;
    localparam logic [3:0] ILLEGAL = 4'd8;

    // Instruction classes
    localparam logic [1:0] K_BAD    = 2'd0;
    localparam logic [1:0] K_BINARY = 2'd1;
    localparam logic [1:0] K_MULDIV = 2'd2;
    localparam logic [1:0] K_UNARY  = 2'd3;

    // Classify an opcode into the micro-sequence it needs.
    function automatic logic [1:0] op_kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: op_kind = K_BINARY;
            5'b01111, 5'b10000:                     op_kind = K_MULDIV;
            5'b10001, 5'b10010:                     op_kind = K_UNARY;
            default:                                op_kind = K_BAD;
        endcase
    endfunction

    // Map an opcode to the ALU operation code.
    function automatic logic [CTRL_W-1:0] op_ctrl(input logic [4:0] op);
        case (op)
            5'b00011: op_ctrl = CTRL_W'(5'b00000); // add
            5'b00100: op_ctrl = CTRL_W'(5'b00001); // sub
            5'b00101: op_ctrl = CTRL_W'(5'b00010); // and
            5'b00110: op_ctrl = CTRL_W'(5'b00011); // or
            5'b00111: op_ctrl = CTRL_W'(5'b00110); // ror
            5'b01000: op_ctrl = CTRL_W'(5'b00111); // rol
            5'b01001: op_ctrl = CTRL_W'(5'b00100); // shr
            5'b01010: op_ctrl = CTRL_W'(5'b01000); // shra
            5'b01011: op_ctrl = CTRL_W'(5'b00101); // shl
            5'b01111: op_ctrl = CTRL_W'(5'b01001); // mul
            5'b10000: op_ctrl = CTRL_W'(5'b01010); // div
            5'b10001: op_ctrl = CTRL_W'(5'b01011); // neg
            5'b10010: op_ctrl = CTRL_W'(5'b01100); // not
            default:  op_ctrl = CTRL_W'(5'b00000);
        endcase
    endfunction

    // One-hot register select.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
        reg_sel = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [3:0]        state_q;
    logic [3:0]        state_d;
    logic [4:0]        op_s;
    logic [3:0]        ra_s;
    logic [3:0]        rb_s;
    logic [3:0]        rc_s;
    logic [1:0]        kind_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic              unused_ir_s;

    assign op_s        = IR[31:27];
    assign ra_s        = IR[26:23];
    assign rb_s        = IR[22:19];
    assign rc_s        = IR[18:15];
    assign kind_s      = op_kind(op_s);
    assign ctrl_s      = op_ctrl(op_s);
    assign unused_ir_s = ^IR[14:0];

    // Next-state logic; Clear overrides everything, ILLEGAL only exits on Clear.
    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Run) begin
                        state_d = T0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                T0: state_d = T1;
                T1: begin
                    if (MemRdy) begin
                        state_d = T2;
                    end else begin
                        state_d = T1;
                    end
                end
                T2: state_d = T3;
                T3: begin
                    if (kind_s == K_BAD) begin
                        state_d = ILLEGAL;
                    end else begin
                        state_d = T4;
                    end
                end
                T4: begin
                    if (kind_s == K_UNARY) begin
                        state_d = IDLE;
                    end else begin
                        state_d = T5;
                    end
                end
                T5: begin
                    if (kind_s == K_MULDIV) begin
                        state_d = T6;
                    end else begin
                        state_d = IDLE;
                    end
                end
                T6:      state_d = IDLE;
                ILLEGAL: state_d = ILLEGAL;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore strobe decode from the current state (and the stable IR fields).
    always_comb begin
        PC_Out  = 1'b0;
        MDR_Out = 1'b0;
        ZLO_Out = 1'b0;
        ZHI_Out = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        MAR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        ZLO_In  = 1'b0;
        ZHI_In  = 1'b0;
        LO_In   = 1'b0;
        HI_In   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        R_Out   = {NUM_REGS{1'b0}};
        R_In    = {NUM_REGS{1'b0}};
        CONTROL = {CTRL_W{1'b0}};
        Done    = 1'b0;
        Fault   = 1'b0;
        case (state_q)
            T0: begin
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
                ZLO_In = 1'b1;
            end
            T1: begin
                ZLO_Out = 1'b1;
                PC_In   = 1'b1;
                Read    = 1'b1;
                MDR_In  = 1'b1;
            end
            T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            T3: begin
                if (kind_s == K_UNARY) begin
                    R_Out   = reg_sel(rb_s);
                    CONTROL = ctrl_s;
                    ZLO_In  = 1'b1;
                end else if (kind_s != K_BAD) begin
                    R_Out = reg_sel(rb_s);
                    Y_In  = 1'b1;
                end else begin
                    Y_In = 1'b0;
                end
            end
            T4: begin
                if (kind_s == K_UNARY) begin
                    ZLO_Out = 1'b1;
                    R_In    = reg_sel(ra_s);
                    Done    = 1'b1;
                end else begin
                    R_Out   = reg_sel(rc_s);
                    CONTROL = ctrl_s;
                    ZLO_In  = 1'b1;
                    ZHI_In  = (kind_s == K_MULDIV);
                end
            end
            T5: begin
                ZLO_Out = 1'b1;
                if (kind_s == K_MULDIV) begin
                    LO_In = 1'b1;
                end else begin
                    R_In = reg_sel(ra_s);
                    Done = 1'b1;
                end
            end
            T6: begin
                ZHI_Out = 1'b1;
                HI_In   = 1'b1;
                Done    = 1'b1;
            end
            ILLEGAL: Fault = 1'b1;
            default: Fault = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer.
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic        Run;
    logic        MemRdy;
    logic [31:0] IR;
    logic        PC_Out, MDR_Out, ZLO_Out, ZHI_Out;
    logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, ZHI_In, LO_In, HI_In;
    logic        IncPC, Read, Done, Fault;
    logic [15:0] R_Out, R_In;
    logic [4:0]  CONTROL;

    control_sequencer #(.NUM_REGS(16), .CTRL_W(5)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .MemRdy(MemRdy), .IR(IR),
        .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out),
        .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
        .ZLO_In(ZLO_In), .ZHI_In(ZHI_In), .LO_In(LO_In), .HI_In(HI_In),
        .IncPC(IncPC), .Read(Read), .R_Out(R_Out), .R_In(R_In),
        .CONTROL(CONTROL), .Done(Done), .Fault(Fault)
    );

    // Strobe bit positions in the packed compare vector
    localparam logic [16:0] S_PC_OUT  = 17'h10000;
    localparam logic [16:0] S_MDR_OUT = 17'h08000;
    localparam logic [16:0] S_ZLO_OUT = 17'h04000;
    localparam logic [16:0] S_ZHI_OUT = 17'h02000;
    localparam logic [16:0] S_PC_IN   = 17'h01000;
    localparam logic [16:0] S_MDR_IN  = 17'h00800;
    localparam logic [16:0] S_MAR_IN  = 17'h00400;
    localparam logic [16:0] S_IR_IN   = 17'h00200;
    localparam logic [16:0] S_Y_IN    = 17'h00100;
    localparam logic [16:0] S_ZLO_IN  = 17'h00080;
    localparam logic [16:0] S_ZHI_IN  = 17'h00040;
    localparam logic [16:0] S_LO_IN   = 17'h00020;
    localparam logic [16:0] S_HI_IN   = 17'h00010;
    localparam logic [16:0] S_INCPC   = 17'h00008;
    localparam logic [16:0] S_READ    = 17'h00004;
    localparam logic [16:0] S_DONE    = 17'h00002;
    localparam logic [16:0] S_FAULT   = 17'h00001;
    localparam logic [16:0] S_NONE    = 17'h00000;

    localparam logic [16:0] X_T0 = S_PC_OUT | S_MAR_IN | S_INCPC | S_ZLO_IN;
    localparam logic [16:0] X_T1 = S_ZLO_OUT | S_PC_IN | S_READ | S_MDR_IN;
    localparam logic [16:0] X_T2 = S_MDR_OUT | S_IR_IN;

    typedef struct {
        logic        clr;
        logic        run;
        logic        rdy;
        logic [31:0] ir;
        logic        chk;
        logic [16:0] str;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  ctl;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add_vec(input logic clr, input logic run, input logic rdy,
                           input logic [31:0] ir, input logic chk, input logic [16:0] str,
                           input logic [15:0] rout, input logic [15:0] rin,
                           input logic [4:0] ctl);
        vec_t v;
        v.clr = clr; v.run = run; v.rdy = rdy; v.ir = ir; v.chk = chk;
        v.str = str; v.rout = rout; v.rin = rin; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    // Full instruction from IDLE back to IDLE; kind 1=binary 2=mul/div 3=unary.
    task automatic seq_instr(input logic [31:0] ir, input int kind, input logic [4:0] ctl,
                             input int stalls);
        logic [15:0] one;
        logic [15:0] sa, sb, sc;
        one = 16'h0001;
        sa  = one << ir[26:23];
        sb  = one << ir[22:19];
        sc  = one << ir[18:15];
        add_vec(1'b0, 1'b1, 1'b1, ir, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);   // IDLE
        add_vec(1'b0, 1'b1, 1'b1, ir, 1'b1, X_T0, 16'h0, 16'h0, 5'd0);     // T0
        for (int s = 0; s < stalls; s++)
            add_vec(1'b0, 1'b1, 1'b0, ir, 1'b1, X_T1, 16'h0, 16'h0, 5'd0); // T1 wait
        add_vec(1'b0, 1'b1, 1'b1, ir, 1'b1, X_T1, 16'h0, 16'h0, 5'd0);     // T1
        add_vec(1'b0, 1'b1, 1'b1, ir, 1'b1, X_T2, 16'h0, 16'h0, 5'd0);     // T2
        if (kind == 3) begin
            add_vec(1'b0, 1'b1, 1'b1, ir, 1'b1, S_ZLO_IN, sb, 16'h0, ctl);
            add_vec(1'b0, 1'b0, 1'b1, ir, 1'b1, S_ZLO_OUT | S_DONE, 16'h0, sa, 5'd0);
        end else begin
            add_vec(1'b0, 1'b1, 1'b1, ir, 1'b1, S_Y_IN, sb, 16'h0, 5'd0);
            add_vec(1'b0, 1'b0, 1'b1, ir, 1'b1,
                    S_ZLO_IN | ((kind == 2) ? S_ZHI_IN : S_NONE), sc, 16'h0, ctl);
            if (kind == 2) begin
                add_vec(1'b0, 1'b0, 1'b1, ir, 1'b1, S_ZLO_OUT | S_LO_IN, 16'h0, 16'h0, 5'd0);
                add_vec(1'b0, 1'b0, 1'b1, ir, 1'b1, S_ZHI_OUT | S_HI_IN | S_DONE,
                        16'h0, 16'h0, 5'd0);
            end else begin
                add_vec(1'b0, 1'b0, 1'b1, ir, 1'b1, S_ZLO_OUT | S_DONE, 16'h0, sa, 5'd0);
            end
        end
    endtask

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        logic [4:0]  ops   [13];
        int          kinds [13];
        logic [4:0]  ctls  [13];
        logic [53:0] got;
        logic [53:0] exp_v;
        logic [3:0]  ra, rb, rc;

        ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};
        kinds = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 3, 3};
        ctls = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00110, 5'b00111, 5'b00100,
                 5'b01000, 5'b00101, 5'b01001, 5'b01010, 5'b01011, 5'b01100};

        Clear = 1'b1; Run = 1'b0; MemRdy = 1'b0; IR = 32'h0;

        // Reset from unknown state, then Clear beats Run in IDLE
        add_vec(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, S_NONE, 16'h0, 16'h0, 5'd0);
        add_vec(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);

        // rol R5,R2,R4 written out by hand
        add_vec(1'b0, 1'b1, 1'b1, 32'h42920000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h42920000, 1'b1, X_T0, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h42920000, 1'b1, X_T1, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h42920000, 1'b1, X_T2, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h42920000, 1'b1, S_Y_IN, 16'h0004, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h42920000, 1'b1, S_ZLO_IN, 16'h0010, 16'h0, 5'b00111);
        add_vec(1'b0, 1'b0, 1'b1, 32'h42920000, 1'b1, S_ZLO_OUT | S_DONE, 16'h0, 16'h0020, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h42920000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);

        // neg R2,R2 by hand
        add_vec(1'b0, 1'b1, 1'b1, 32'h89100000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h89100000, 1'b1, X_T0, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h89100000, 1'b1, X_T1, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h89100000, 1'b1, X_T2, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h89100000, 1'b1, S_ZLO_IN, 16'h0004, 16'h0, 5'b01011);
        add_vec(1'b0, 1'b0, 1'b1, 32'h89100000, 1'b1, S_ZLO_OUT | S_DONE, 16'h0, 16'h0004, 5'd0);

        // MemRdy low for three cycles on an add, then mul R1,R4,R4
        seq_instr(32'h18918000, 1, 5'b00000, 3);
        seq_instr(32'h78A20000, 2, 5'b01001, 0);

        // Every legal opcode with distinct register fields
        for (int i = 0; i < 13; i++) begin
            ra = 4'(i);
            rb = 4'(i + 3);
            rc = 4'(i + 7);
            seq_instr({ops[i], ra, rb, rc, 15'h0}, kinds[i], ctls[i], i % 2);
        end

        // Illegal opcode: sticky Fault until Clear
        add_vec(1'b0, 1'b1, 1'b1, 32'hF8000000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b1, 1'b1, 32'hF8000000, 1'b1, X_T0, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b1, 1'b1, 32'hF8000000, 1'b1, X_T1, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b1, 1'b1, 32'hF8000000, 1'b1, X_T2, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b1, 1'b1, 32'hF8000000, 1'b0, S_NONE, 16'h0, 16'h0, 5'd0);
        for (int k = 0; k < 3; k++)
            add_vec(1'b0, 1'b1, 1'b1, 32'hF8000000, 1'b1, S_FAULT, 16'h0, 16'h0, 5'd0);
        add_vec(1'b1, 1'b1, 1'b1, 32'hF8000000, 1'b1, S_FAULT, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'hF8000000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'hF8000000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);

        // Clear during T4 of add R1,R2,R3: no R_In pulse afterwards
        add_vec(1'b0, 1'b1, 1'b1, 32'h18918000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h18918000, 1'b1, X_T0, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h18918000, 1'b1, X_T1, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h18918000, 1'b1, X_T2, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h18918000, 1'b1, S_Y_IN, 16'h0004, 16'h0, 5'd0);
        add_vec(1'b1, 1'b0, 1'b1, 32'h18918000, 1'b1, S_ZLO_IN, 16'h0008, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h18918000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h18918000, 1'b1, S_NONE, 16'h0, 16'h0, 5'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clock);
            Clear  = vecs[i].clr;
            Run    = vecs[i].run;
            MemRdy = vecs[i].rdy;
            IR     = vecs[i].ir;
            #1;
            if (vecs[i].chk) begin
                checks++;
                got = {PC_Out, MDR_Out, ZLO_Out, ZHI_Out, PC_In, MDR_In, MAR_In, IR_In,
                       Y_In, ZLO_In, ZHI_In, LO_In, HI_In, IncPC, Read, Done, Fault,
                       R_Out, R_In, CONTROL};
                exp_v = {vecs[i].str, vecs[i].rout, vecs[i].rin, vecs[i].ctl};
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL vec%0d strobes/rout/rin/ctl got=%h/%h/%h/%h exp=%h/%h/%h/%h",
                             i, got[53:37], got[36:21], got[20:5], got[4:0],
                             exp_v[53:37], exp_v[36:21], exp_v[20:5], exp_v[4:0]);
                end
            end
        end

        @(negedge Clock);
        Clear  = 1'b1;
        Run    = 1'b0;
        MemRdy = 1'b0;
        IR     = 32'h0;
        @(negedge Clock);
        Clear = 1'b0;
        #1;
        checks++;
        got = {PC_Out, MDR_Out, ZLO_Out, ZHI_Out, PC_In, MDR_In, MAR_In, IR_In,
               Y_In, ZLO_In, ZHI_In, LO_In, HI_In, IncPC, Read, Done, Fault,
               R_Out, R_In, CONTROL};
        if (got !== 54'h0) begin
            failures++;
            $display("FAIL reset-state outputs got=%h exp=0", got);
        end

        Run = 1'b1;
        IR  = 32'h18918000;
        @(negedge Clock);
        Run    = 1'b0;
        MemRdy = 1'b0;
        for (int w = 0; w < 4; w++) begin
            @(negedge Clock);
            #1;
            checks++;
            if ({Read, MDR_In, PC_In, ZLO_Out, MAR_In, IR_In} !== 6'b111100) begin
                failures++;
                $display("FAIL wait cycle %0d Read/MDR_In/PC_In/ZLO_Out/MAR_In/IR_In=%b",
                         w, {Read, MDR_In, PC_In, ZLO_Out, MAR_In, IR_In});
            end
        end
        MemRdy = 1'b1;
        @(negedge Clock);
        #1;
        checks++;
        if ({MDR_Out, IR_In, Read, MDR_In, PC_In, Done} !== 6'b110000) begin
            failures++;
            $display("FAIL expired wait MDR_Out/IR_In/Read/MDR_In/PC_In/Done=%b",
                     {MDR_Out, IR_In, Read, MDR_In, PC_In, Done});
        end
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;

        @(negedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
